// File: rtl/gfx_pkg.sv
// gfx_pkg: shared FSM states, tilemap entry fields, sprite heights and zdepth values
// for the scanline fetch sequencer.
package gfx_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_LAYER_SEL, ST_MAP_REQ, ST_MAP_RD, ST_PAT_HI, ST_PAT_LO, ST_SPR, ST_DONE
    } state_t;
    localparam int ME_PRIO  = 10;
    localparam int ME_HFLIP = 11;
    localparam int ME_VFLIP = 12;
    localparam int ME_PAL   = 13;
    localparam logic [3:0] SPR_H8  = 4'd7;
    localparam logic [3:0] SPR_H16 = 4'd15;
    localparam logic [1:0] ZD_OFF  = 2'd0;
    function automatic logic [15:0] bswap16(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction
endpackage

// File: rtl/gfx_spr_line_test.sv
// gfx_spr_line_test: decides whether a sprite covers the current line and forms the
// word address (without bit 0) of its pattern row.
module gfx_spr_line_test
    import gfx_pkg::*;
(
    input  logic [7:0]  i_vline,
    input  logic [7:0]  i_spr_y,
    input  logic [9:0]  i_spr_idx,
    input  logic        i_spr_h16,
    input  logic        i_spr_vflip,
    input  logic [1:0]  i_spr_zdepth,
    output logic        o_on_line,
    output logic [12:0] o_pat
);
    logic [7:0] w_ydiff;
    logic [3:0] w_h;
    logic [3:0] w_sl;

    assign w_ydiff   = i_vline - i_spr_y;
    assign w_h       = i_spr_h16 ? SPR_H16 : SPR_H8;
    assign w_sl      = i_spr_vflip ? w_h - w_ydiff[3:0] : w_ydiff[3:0];
    assign o_on_line = (w_ydiff <= {4'd0, w_h}) && (i_spr_zdepth != ZD_OFF);
    // 16-px sprites use the odd pattern index for their lower half
    assign o_pat     = {i_spr_idx[9:1], i_spr_idx[0] ^ w_sl[3], w_sl[2:0]};
endmodule

// File: rtl/gfx_line_fetch_ml.sv
// gfx_line_fetch_ml: per-scanline tile-layer and sprite fetch sequencer feeding the renderer.
// Define GFX_SPR_LIMIT_EN to cap issued sprites per line at MAX_SPR_LINE and flag overflow.
module gfx_line_fetch_ml
    import gfx_pkg::*;
#(
    parameter int NUM_LAYERS   = 2,
    parameter int COLS         = 41,
    parameter int NUM_SPRITES  = 256,
    parameter int MAX_SPR_LINE = 64,
    parameter int VADDR_W      = 14
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_start,
    input  logic [7:0]                    i_vline,
    input  logic                          i_gfx_enable,
    input  logic [NUM_LAYERS-1:0]         i_layer_en,
    input  logic                          i_spr_en,
    input  logic [9*NUM_LAYERS-1:0]       i_layer_scrx,
    input  logic [8*NUM_LAYERS-1:0]       i_layer_scry,
    input  logic [VADDR_W*NUM_LAYERS-1:0] i_layer_map,
    input  logic [2*NUM_LAYERS-1:0]       i_layer_prio,
    output logic [$clog2(NUM_SPRITES)-1:0] o_spr_sel,
    input  logic [8:0]                    i_spr_x,
    input  logic [7:0]                    i_spr_y,
    input  logic [9:0]                    i_spr_idx,
    input  logic                          i_spr_h16,
    input  logic [1:0]                    i_spr_zdepth,
    input  logic [2:0]                    i_spr_palette,
    input  logic                          i_spr_hflip,
    input  logic                          i_spr_vflip,
    output logic [VADDR_W-1:0]            o_vaddr,
    input  logic [15:0]                   i_vdata,
    output logic                          o_rnd_start,
    output logic [8:0]                    o_rnd_idx,
    output logic [31:0]                   o_rnd_data,
    output logic                          o_rnd_hflip,
    output logic [2:0]                    o_rnd_palette,
    output logic [2:0]                    o_rnd_zdepth,
    output logic                          o_rnd_zinit,
    input  logic                          i_rnd_busy,
    input  logic                          i_rnd_last,
    output logic                          o_linesel,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_spr_overflow
);
    localparam int CW = $clog2(COLS + 1);

    state_t                    r_state, w_next_state;
    logic [2:0]                r_layer, w_next_layer, w_l;
    logic                      w_found;
    logic [8:0]                w_scrx;
    logic [7:0]                w_scry, w_tline, r_vline;
    logic [VADDR_W-1:0]        w_map;
    logic [1:0]                w_prio;
    logic [5:0]                r_col;
    logic [CW-1:0]             r_cnt;
    logic [8:0]                r_x;
    logic [12:0]               r_pat, w_tile_pat, w_spr_pat;
    logic [15:0]               r_hi;
    logic                      r_hflip, r_spr_mode, r_spr_last, r_zinit, r_linesel;
    logic [2:0]                r_pal, r_zd;
    logic                      w_on_line, w_ready, w_issue, w_cols_done, w_spr_stop;
    logic                      r_rnd_start, r_rnd_hflip, r_rnd_zinit;
    logic [8:0]                r_rnd_idx;
    logic [31:0]               r_rnd_data;
    logic [2:0]                r_rnd_pal, r_rnd_zd;
    logic [$clog2(NUM_SPRITES)-1:0] r_spr_sel;

    gfx_spr_line_test u_spr (
        .i_vline(r_vline), .i_spr_y(i_spr_y), .i_spr_idx(i_spr_idx), .i_spr_h16(i_spr_h16),
        .i_spr_vflip(i_spr_vflip), .i_spr_zdepth(i_spr_zdepth),
        .o_on_line(w_on_line), .o_pat(w_spr_pat)
    );

    always_comb begin
        w_found      = 1'b0;
        w_next_layer = '0;
        for (int l = NUM_LAYERS - 1; l >= 0; l--)
            if (i_layer_en[l] && 3'(l) >= r_layer) begin
                w_found      = 1'b1;
                w_next_layer = 3'(l);
            end
    end

    // while selecting, fetch the scroll of the layer about to be entered
    assign w_l = (r_state == ST_LAYER_SEL) ? w_next_layer : r_layer;

    always_comb begin
        w_scrx = '0;
        w_scry = '0;
        w_map  = '0;
        w_prio = '0;
        for (int l = 0; l < NUM_LAYERS; l++)
            if (w_l == 3'(l)) begin
                w_scrx = i_layer_scrx[9*l +: 9];
                w_scry = i_layer_scry[8*l +: 8];
                w_map  = i_layer_map[VADDR_W*l +: VADDR_W];
                w_prio = i_layer_prio[2*l +: 2];
            end
    end

    assign w_tline     = r_vline + w_scry;
    assign w_tile_pat  = {i_vdata[9:0], i_vdata[ME_VFLIP] ? ~w_tline[2:0] : w_tline[2:0]};
    assign w_ready     = !i_rnd_busy || i_rnd_last;
    assign w_issue     = (r_state == ST_PAT_LO) && w_ready;
    assign w_cols_done = r_cnt == CW'(COLS - 1);

`ifdef GFX_SPR_LIMIT_EN
    localparam int LW = $clog2(MAX_SPR_LINE + 1);
    logic [LW-1:0] r_spr_cnt;
    logic          r_ovf;
    assign w_spr_stop     = w_on_line && (r_spr_cnt == LW'(MAX_SPR_LINE));
    assign o_spr_overflow = r_ovf;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_spr_cnt <= '0;
            r_ovf     <= 1'b0;
        end else if (i_start) begin
            r_spr_cnt <= '0;
            r_ovf     <= 1'b0;
        end else if (r_state == ST_SPR) begin
            if (w_spr_stop) r_ovf <= 1'b1;
            else if (w_on_line) r_spr_cnt <= r_spr_cnt + 1'b1;
        end
`else
    assign w_spr_stop     = 1'b0;
    assign o_spr_overflow = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= ST_IDLE;
        else r_state <= w_next_state;

    always_comb begin
        w_next_state = r_state;
        o_vaddr      = '0;
        case (r_state)
            ST_LAYER_SEL: w_next_state = w_found ? ST_MAP_REQ :
                                         (i_spr_en && i_gfx_enable) ? ST_SPR : ST_DONE;
            ST_MAP_REQ: begin
                w_next_state = ST_MAP_RD;
                o_vaddr      = w_map + VADDR_W'({w_tline[7:3], r_col});
            end
            ST_MAP_RD: begin
                w_next_state = ST_PAT_HI;
                o_vaddr      = VADDR_W'({w_tile_pat, 1'b0});
            end
            ST_PAT_HI: begin
                w_next_state = ST_PAT_LO;
                o_vaddr      = VADDR_W'({r_pat, 1'b1});
            end
            ST_PAT_LO: begin
                o_vaddr = VADDR_W'({r_pat, 1'b1});
                if (w_ready)
                    w_next_state = r_spr_mode ? (r_spr_last ? ST_DONE : ST_SPR) :
                                   (w_cols_done ? ST_LAYER_SEL : ST_MAP_REQ);
            end
            ST_SPR: begin
                o_vaddr      = VADDR_W'({w_spr_pat, 1'b0});
                w_next_state = w_spr_stop ? ST_DONE : w_on_line ? ST_PAT_HI :
                               (&r_spr_sel) ? ST_DONE : ST_SPR;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: ;
        endcase
        if (i_start) w_next_state = ST_LAYER_SEL;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_layer     <= '0;
            r_vline     <= '0;
            r_col       <= '0;
            r_cnt       <= '0;
            r_x         <= '0;
            r_pat       <= '0;
            r_hi        <= '0;
            r_hflip     <= 1'b0;
            r_pal       <= '0;
            r_zd        <= '0;
            r_spr_mode  <= 1'b0;
            r_spr_last  <= 1'b0;
            r_zinit     <= 1'b0;
            r_linesel   <= 1'b0;
            r_spr_sel   <= '0;
            r_rnd_start <= 1'b0;
            r_rnd_idx   <= '0;
            r_rnd_data  <= '0;
            r_rnd_hflip <= 1'b0;
            r_rnd_pal   <= '0;
            r_rnd_zd    <= '0;
            r_rnd_zinit <= 1'b0;
        end else begin
            r_rnd_start <= 1'b0;
            if (i_start) begin
                r_linesel  <= ~r_linesel;
                r_layer    <= '0;
                r_spr_sel  <= '0;
                r_zinit    <= 1'b1;
                r_vline    <= i_vline;
                r_spr_mode <= 1'b0;
            end else begin
                if (r_state == ST_LAYER_SEL && w_found) begin
                    r_layer <= w_next_layer;
                    r_col   <= w_scrx[8:3];
                    r_cnt   <= '0;
                    r_x     <= 9'd0 - {6'd0, w_scrx[2:0]};
                end
                if (r_state == ST_MAP_RD) begin
                    r_pat   <= w_tile_pat;
                    r_hflip <= i_vdata[ME_HFLIP];
                    r_pal   <= i_vdata[ME_PAL +: 3];
                    r_zd    <= {w_prio, i_vdata[ME_PRIO]};
                end
                if (r_state == ST_PAT_HI) r_hi <= i_vdata;
                // second pattern word is still on vdata while PAT_LO waits for the renderer
                if (w_issue) begin
                    r_rnd_start <= 1'b1;
                    r_rnd_idx   <= r_x;
                    r_rnd_data  <= i_gfx_enable ? {bswap16(r_hi), bswap16(i_vdata)} : 32'd0;
                    r_rnd_hflip <= r_hflip;
                    r_rnd_pal   <= r_pal;
                    r_rnd_zd    <= r_zd;
                    r_rnd_zinit <= r_zinit;
                    r_x         <= r_x + 9'd8;
                    r_col       <= r_col + 6'd1;
                    r_cnt       <= r_cnt + 1'b1;
                    if (w_cols_done && !r_spr_mode) begin
                        r_layer <= r_layer + 3'd1;
                        r_zinit <= 1'b0;
                    end
                end
                if (r_state == ST_SPR) begin
                    r_spr_sel  <= r_spr_sel + 1'b1;
                    r_spr_last <= &r_spr_sel;
                    if (w_on_line) begin
                        r_spr_mode <= 1'b1;
                        r_pat      <= w_spr_pat;
                        r_hflip    <= i_spr_hflip;
                        r_pal      <= i_spr_palette;
                        r_zd       <= {i_spr_zdepth, 1'b0};
                        r_x        <= i_spr_x;
                    end
                end
            end
        end

    assign o_spr_sel     = r_spr_sel;
    assign o_rnd_start   = r_rnd_start;
    assign o_rnd_idx     = r_rnd_idx;
    assign o_rnd_data    = r_rnd_data;
    assign o_rnd_hflip   = r_rnd_hflip;
    assign o_rnd_palette = r_rnd_pal;
    assign o_rnd_zdepth  = r_rnd_zd;
    assign o_rnd_zinit   = r_rnd_zinit;
    assign o_linesel     = r_linesel;
    assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_done        = r_state == ST_DONE;
endmodule
